rf_read_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-input, 5-bit-select read multiplexer between 32 requesters. It produces a registered `grant_select` that drives the mux `select` input directly, plus a valid/ready handshake toward the consumer of the mux output. Each granted requester may hold the mux for a bounded burst of beats before the grant rotates. The block sits between the requesting units and the mux select port, and is the only source of that select.

---
 rtl/rf_read_arbiter_if.sv | 28 ++
 rtl/rf_read_arbiter.sv | 95 +++++++++
 tb/tb_rf_read_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rf_read_arbiter_if.sv
// Request/grant bundle between the read-mux requesters, the mux consumer and the
// round-robin arbiter that owns the mux select.
interface rf_read_arbiter_if;
  logic [31:0] req;
  logic        out_ready;
  logic        grant_valid;
  logic [4:0]  grant_select;
  logic [31:0] grant_onehot;
  logic        grant_last;

  modport master (
    input  req,
    input  out_ready,
    output grant_valid,
    output grant_select,
    output grant_onehot,
    output grant_last
  );

  modport slave (
    output req,
    output out_ready,
    input  grant_valid,
    input  grant_select,
    input  grant_onehot,
    input  grant_last
  );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter for the 32:1 register-file read mux with bounded bursts per grant.
// Hand-offs re-arbitrate in the releasing edge, so grant_valid never bubbles between owners.
module rf_read_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  rf_read_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] ptr;
  logic [4:0] ptr_nxt;
  logic [4:0] sel;
  logic [4:0] sel_nxt;
  logic [3:0] beat_cnt;
  logic [3:0] beat_nxt;
  logic [4:0] rel_ptr;
  logic [5:0] idle_hit;
  logic [5:0] rel_hit;

  // Returns {found, index} of the first set request scanning start, start+1, ... mod 32.
  function automatic logic [5:0] rr_search(input logic [31:0] req, input logic [4:0] start);
    logic [5:0] res;
    logic [4:0] idx;
    res = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = start + 5'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rel_ptr  = sel + 5'd1;
  assign idle_hit = rr_search(bus.req, ptr);
  assign rel_hit  = rr_search(bus.req, rel_ptr);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (idle_hit[5]) begin
          sel_nxt   = idle_hit[4:0];
          beat_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (bus.out_ready) begin
          if (bus.req[sel] && (beat_cnt < LAST_BEAT)) begin
            beat_nxt = beat_cnt + 4'd1;
          end else begin
            // Released owner sits last in the new search order.
            ptr_nxt = rel_ptr;
            if (rel_hit[5]) begin
              sel_nxt  = rel_hit[4:0];
              beat_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  assign bus.grant_valid  = (state == GRANT);
  assign bus.grant_select = sel;
  assign bus.grant_onehot = (state == GRANT) ? (32'd1 << sel) : '0;
  assign bus.grant_last   = (state == GRANT) && (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: reset, burst limit, round-robin order, wrap,
// early release, backpressure and asynchronous reset mid-grant.
module tb_rf_read_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  rf_read_arbiter_if bus();

  rf_read_arbiter #(.BURST_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [31:0] req_v);
    reset = 1'b1;
    bus.req = req_v;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_grant(input string tag, input logic [4:0] sel, input logic [3:0] beat,
                             input logic last);
    check({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
    check({tag, "_sel"}, 32'(bus.grant_select), 32'(sel));
    check({tag, "_onehot"}, bus.grant_onehot, 32'd1 << sel);
    check({tag, "_last"}, 32'(bus.grant_last), 32'(last));
    check({tag, "_beat"}, 32'(dut.beat_cnt), 32'(beat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rr_order [4];
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.req = '1;
    bus.out_ready = 1'b1;

    // Reset with every requester asking.
    tick();
    tick();
    check("rst_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_sel", 32'(bus.grant_select), 32'd0);
    check("rst_onehot", bus.grant_onehot, 32'd0);
    check("rst_last", 32'(bus.grant_last), 32'd0);
    reset = 1'b0;
    bus.req = 32'h1;
    tick();
    check_grant("first", 5'd0, 4'd0, 1'b0);

    // Burst limit with a lone requester 7, then back-to-back re-grant.
    restart(32'd1 << 7);
    tick();
    for (int b = 0; b < 4; b++) begin
      check_grant($sformatf("burst%0d", b), 5'd7, 4'(b), (b == 3));
      tick();
    end
    check_grant("regrant7", 5'd7, 4'd0, 1'b0);

    // Round-robin between 3 and 20.
    rr_order[0] = 5'd3;
    rr_order[1] = 5'd20;
    rr_order[2] = 5'd3;
    rr_order[3] = 5'd20;
    restart((32'd1 << 3) | (32'd1 << 20));
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rr%0d_sel", k), 32'(bus.grant_select), 32'(rr_order[k / 4]));
      check($sformatf("rr%0d_valid", k), 32'(bus.grant_valid), 32'd1);
      tick();
    end

    // Wrap-around and early release of 31.
    restart(32'd1 << 31);
    tick();
    check_grant("wrap_b0", 5'd31, 4'd0, 1'b0);
    bus.req = (32'd1 << 31) | (32'd1 << 30) | 32'd1;
    tick();
    check_grant("wrap_b1", 5'd31, 4'd1, 1'b0);
    bus.req = (32'd1 << 30) | 32'd1;
    tick();
    check_grant("wrap_next", 5'd0, 4'd0, 1'b0);

    // Hand off 3 -> 12 so ptr is non-zero, then backpressure and async reset.
    restart(32'd1 << 3);
    tick();
    check_grant("bp_pre", 5'd3, 4'd0, 1'b0);
    bus.req = 32'd1 << 12;
    tick();
    check_grant("bp_g12", 5'd12, 4'd0, 1'b0);
    tick();
    check_grant("bp_b1", 5'd12, 4'd1, 1'b0);
    bus.out_ready = 1'b0;
    bus.req = (32'd1 << 2) | (32'd1 << 12);
    for (int c = 0; c < 10; c++) begin
      tick();
      check_grant($sformatf("bp%0d", c), 5'd12, 4'd1, 1'b0);
    end
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.grant_valid), 32'd0);
    check("arst_sel", 32'(bus.grant_select), 32'd0);
    check("arst_onehot", bus.grant_onehot, 32'd0);
    check("arst_last", 32'(bus.grant_last), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_grant("arst_restart", 5'd2, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
